// File: rtl/tile_bram_manager.sv
// Tile buffer manager: banked row-per-word storage with
// whole-tile read and write sequencing.
module tile_bram_manager #(
  parameter int DATA_W = 8,
  parameter int ROWS = 16,
  parameter int COLS = 128,
  parameter int N_MAT = 4,
  parameter int N_TILE = 64,
  parameter int BRAM_LAT = 2,
  parameter logic [N_MAT-1:0] WR_MASK = N_MAT'(4'b1000),
  localparam int MW = (N_MAT > 1) ? $clog2(N_MAT) : 1,
  localparam int TW = (N_TILE > 1) ? $clog2(N_TILE) : 1
) (
  input  logic I_CLK,
  input  logic I_RST_N,
  input  logic I_RD_ENA_PULSE,
  input  logic I_WR_ENA_PULSE,
  input  logic [MW+TW-1:0] I_SEL,
  input  logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] I_MAT,
  output logic O_VLD,
  output logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] O_MAT,
  output logic O_WR_DONE,
  output logic O_BUSY,
  output logic O_ERR
);

  localparam int DEPTH = N_MAT * N_TILE * ROWS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_RD_DONE = 3'd3;
  localparam logic [2:0] S_WR = 3'd4;
  localparam logic [2:0] S_WR_DONE = 3'd5;

  typedef logic [0:COLS-1][DATA_W-1:0] row_t;

  row_t mem [DEPTH] = '{default: '0};

  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [1:0] dcnt;
  logic [AW-1:0] base;
  logic [AW-1:0] addr;
  logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] shadow;

  row_t rpipe [BRAM_LAT];
  logic [BRAM_LAT-1:0] vpipe;
  logic [CW-1:0] rowpipe [BRAM_LAT];

  logic [MW-1:0] sel_bank;
  logic [TW-1:0] sel_tile;
  logic any_req;
  logic bad_sel;
  logic reject;

  assign sel_bank = I_SEL[MW+TW-1:TW];
  assign sel_tile = I_SEL[TW-1:0];
  assign any_req = I_RD_ENA_PULSE | I_WR_ENA_PULSE;
  assign addr = base + AW'(cnt);

  assign O_BUSY = (state != S_IDLE);
  assign O_VLD = (state == S_RD_DONE);
  assign O_WR_DONE = (state == S_WR_DONE);

  always_comb begin
    bad_sel = (int'(sel_bank) >= N_MAT) ||
              (int'(sel_tile) >= N_TILE);
    reject = (I_RD_ENA_PULSE & I_WR_ENA_PULSE) |
             (any_req & bad_sel);
    if (I_WR_ENA_PULSE && !bad_sel && !WR_MASK[sel_bank])
      reject = 1'b1;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= S_IDLE;
      cnt <= '0;
      dcnt <= '0;
      base <= '0;
      shadow <= '0;
      O_ERR <= 1'b0;
    end else begin
      O_ERR <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            O_ERR <= reject;
            if (!reject) begin
              base <= AW'((int'(sel_bank) * N_TILE
                          + int'(sel_tile)) * ROWS);
              cnt <= '0;
              if (I_WR_ENA_PULSE) begin
                shadow <= I_MAT;
                state <= S_WR;
              end else begin
                state <= S_RD_ISSUE;
              end
            end
          end
        end
        S_RD_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ROWS - 1)) begin
            state <= S_RD_DRAIN;
            dcnt <= '0;
          end
        end
        S_RD_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'(BRAM_LAT - 1))
            state <= S_RD_DONE;
        end
        S_WR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ROWS - 1))
            state <= S_WR_DONE;
        end
        S_RD_DONE, S_WR_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // any pulse outside IDLE is dropped and flagged
      if (state != S_IDLE && any_req)
        O_ERR <= 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (state == S_WR)
      mem[addr] <= shadow[cnt];
    if (state == S_RD_ISSUE)
      rpipe[0] <= mem[addr];
    for (int j = 1; j < BRAM_LAT; j++)
      rpipe[j] <= rpipe[j-1];
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      vpipe <= '0;
      O_MAT <= '0;
      for (int j = 0; j < BRAM_LAT; j++)
        rowpipe[j] <= '0;
    end else begin
      vpipe[0] <= (state == S_RD_ISSUE);
      rowpipe[0] <= cnt;
      for (int j = 1; j < BRAM_LAT; j++) begin
        vpipe[j] <= vpipe[j-1];
        rowpipe[j] <= rowpipe[j-1];
      end
      if (vpipe[BRAM_LAT-1])
        O_MAT[rowpipe[BRAM_LAT-1]] <= rpipe[BRAM_LAT-1];
    end
  end

endmodule

// File: tb/tb_tile_bram_manager.sv
// Directed bench for tile_bram_manager: default build plus a
// small low-latency build, with a queue scoreboard per build.
module tb_tile_bram_manager;

  localparam int R1 = 16, C1 = 128, D1 = 8, L1 = 2;
  localparam int R2 = 4, C2 = 8, D2 = 16, L2 = 1, T2 = 70;

  typedef logic [0:R1-1][0:C1-1][D1-1:0] m1_t;
  typedef logic [0:R2-1][0:C2-1][D2-1:0] m2_t;
  typedef struct { m1_t mat; int at; } e1_t;
  typedef struct { m2_t mat; int at; } e2_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic rd1 = 1'b0, wr1 = 1'b0;
  logic [7:0] sel1 = '0;
  m1_t imat1 = '0;
  m1_t omat1;
  logic vld1, wd1, busy1, err1;

  logic rd2 = 1'b0, wr2 = 1'b0;
  logic [8:0] sel2 = '0;
  m2_t imat2 = '0;
  m2_t omat2;
  logic vld2, wd2, busy2, err2;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  e1_t rq1[$];
  int wq1[$];
  e2_t rq2[$];
  int wq2[$];
  m1_t model1 [int];
  m2_t model2 [int];
  e1_t pe1;
  e2_t pe2;

  tile_bram_manager u_dut1 (
    .I_CLK(clk), .I_RST_N(rst_n),
    .I_RD_ENA_PULSE(rd1), .I_WR_ENA_PULSE(wr1),
    .I_SEL(sel1), .I_MAT(imat1),
    .O_VLD(vld1), .O_MAT(omat1), .O_WR_DONE(wd1),
    .O_BUSY(busy1), .O_ERR(err1)
  );

  tile_bram_manager #(
    .DATA_W(D2), .ROWS(R2), .COLS(C2),
    .N_TILE(T2), .BRAM_LAT(L2)
  ) u_dut2 (
    .I_CLK(clk), .I_RST_N(rst_n),
    .I_RD_ENA_PULSE(rd2), .I_WR_ENA_PULSE(wr2),
    .I_SEL(sel2), .I_MAT(imat2),
    .O_VLD(vld2), .O_MAT(omat2), .O_WR_DONE(wd2),
    .O_BUSY(busy2), .O_ERR(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_m1(input string tag,
                        input m1_t obs, input m1_t exp);
    int r0 = 0, c0 = 0;
    bit hit = 0;
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < C1; c++)
        if (!hit && obs[r][c] !== exp[r][c]) begin
          hit = 1; r0 = r; c0 = c;
        end
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: row %0d col %0d got %0h want %0h",
                tag, r0, c0, obs[r0][c0], exp[r0][c0]);
  endtask

  task automatic chk_m2(input string tag,
                        input m2_t obs, input m2_t exp);
    int r0 = 0, c0 = 0;
    bit hit = 0;
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++)
        if (!hit && obs[r][c] !== exp[r][c]) begin
          hit = 1; r0 = r; c0 = c;
        end
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: row %0d col %0d got %0h want %0h",
                tag, r0, c0, obs[r0][c0], exp[r0][c0]);
  endtask

  function automatic m1_t pat1(input logic [31:0] seed,
                               input bit mix);
    m1_t m;
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < C1; c++)
        m[r][c] = 8'(seed >> (8 * (r % 4)))
                  ^ (mix ? 8'(c + r) : 8'h00);
    return m;
  endfunction

  function automatic m2_t pat2(input logic [31:0] seed);
    m2_t m;
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++)
        m[r][c] = {2{8'(seed >> (8 * (r % 4)))}};
    return m;
  endfunction

  function automatic m1_t get1(input int k);
    return model1.exists(k) ? model1[k] : '0;
  endfunction

  function automatic m2_t get2(input int k);
    return model2.exists(k) ? model2[k] : '0;
  endfunction

  // scoreboard: completion pulses pop the oldest expectation
  always @(negedge clk) begin
    if (vld1) begin
      n_chk++;
      assert (rq1.size() > 0) n_pass++;
      else $error("FAIL vld1_unexpected: got pulse want none");
      if (rq1.size() > 0) begin
        pe1 = rq1.pop_front();
        chk("vld1_cycle", 32'(cyc), 32'(pe1.at));
        chk_m1("omat1", omat1, pe1.mat);
      end
    end
    if (wd1) begin
      n_chk++;
      assert (wq1.size() > 0) n_pass++;
      else $error("FAIL wd1_unexpected: got pulse want none");
      if (wq1.size() > 0)
        chk("wd1_cycle", 32'(cyc), 32'(wq1.pop_front()));
    end
    if (vld2) begin
      n_chk++;
      assert (rq2.size() > 0) n_pass++;
      else $error("FAIL vld2_unexpected: got pulse want none");
      if (rq2.size() > 0) begin
        pe2 = rq2.pop_front();
        chk("vld2_cycle", 32'(cyc), 32'(pe2.at));
        chk_m2("omat2", omat2, pe2.mat);
      end
    end
    if (wd2) begin
      n_chk++;
      assert (wq2.size() > 0) n_pass++;
      else $error("FAIL wd2_unexpected: got pulse want none");
      if (wq2.size() > 0)
        chk("wd2_cycle", 32'(cyc), 32'(wq2.pop_front()));
    end
  end

  task automatic wait1(input int idle_at);
    int n = 0;
    while (busy1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("idle1_cycle", 32'(cyc), 32'(idle_at));
  endtask

  task automatic wait2(input int idle_at);
    int n = 0;
    while (busy2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("idle2_cycle", 32'(cyc), 32'(idle_at));
  endtask

  task automatic rd_t1(input int bank, input int tile);
    int a;
    e1_t e;
    sel1 = 8'(bank * 64 + tile);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    sel1 = ~sel1;
    a = cyc;
    e.mat = get1(bank * 64 + tile);
    e.at = a + R1 + L1;
    rq1.push_back(e);
    chk("rd1_busy", 32'(busy1), 1);
    wait1(a + R1 + L1 + 1);
  endtask

  task automatic wr_t1(input int bank, input int tile,
                       input m1_t d, input bit ok);
    int a;
    sel1 = 8'(bank * 64 + tile);
    imat1 = d;
    wr1 = 1'b1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    sel1 = ~sel1;
    imat1 = ~d;
    a = cyc;
    if (ok) begin
      model1[bank * 64 + tile] = d;
      wq1.push_back(a + R1);
      chk("wr1_busy", 32'(busy1), 1);
      wait1(a + R1 + 1);
    end else begin
      chk("rej1_err", 32'(err1), 1);
      chk("rej1_busy", 32'(busy1), 0);
      @(posedge clk); #1;
      chk("rej1_err_drop", 32'(err1), 0);
    end
  endtask

  task automatic rd_t2(input int bank, input int tile);
    int a;
    e2_t e;
    sel2 = 9'(bank * 128 + tile);
    rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0;
    sel2 = ~sel2;
    a = cyc;
    e.mat = get2(bank * 128 + tile);
    e.at = a + R2 + L2;
    rq2.push_back(e);
    chk("rd2_busy", 32'(busy2), 1);
    wait2(a + R2 + L2 + 1);
  endtask

  task automatic wr_t2(input int bank, input int tile,
                       input m2_t d);
    int a;
    sel2 = 9'(bank * 128 + tile);
    imat2 = d;
    wr2 = 1'b1;
    @(posedge clk); #1;
    wr2 = 1'b0;
    sel2 = ~sel2;
    imat2 = ~d;
    a = cyc;
    model2[bank * 128 + tile] = d;
    wq2.push_back(a + R2);
    wait2(a + R2 + 1);
  endtask

  initial begin
    int a;
    m1_t nd, md;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_vld", 32'(vld1), 0);
    chk_m1("rst_omat", omat1, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fresh read, then write/readback back to back
    rd_t1(0, 0);
    wr_t1(3, 5, pat1(32'h88776655, 0), 1);
    rd_t1(3, 5);

    // rejected requests
    wr_t1(0, 0, pat1(32'h11223344, 1), 0);
    sel1 = 8'(3 * 64 + 5);
    imat1 = pat1(32'hdeadbeef, 1);
    rd1 = 1'b1;
    wr1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    wr1 = 1'b0;
    chk("both_err", 32'(err1), 1);
    chk("both_busy", 32'(busy1), 0);
    @(posedge clk); #1;
    chk("both_err_drop", 32'(err1), 0);
    rd_t1(0, 0);
    rd_t1(3, 5);
    rd_t1(2, 7);

    // read pulse during a write is flagged and dropped
    sel1 = 8'(3 * 64 + 9);
    imat1 = pat1(32'h0f1e2d3c, 1);
    wr1 = 1'b1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    a = cyc;
    model1[3 * 64 + 9] = imat1;
    wq1.push_back(a + R1);
    repeat (3) @(posedge clk);
    #1;
    sel1 = 8'(3 * 64 + 5);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    chk("busy_err", 32'(err1), 1);
    chk("busy_still", 32'(busy1), 1);
    wait1(a + R1 + 1);
    rd_t1(3, 9);

    // reset after eight rows of a write
    nd = pat1(32'ha1b2c3d4, 1);
    sel1 = 8'(3 * 64 + 5);
    imat1 = nd;
    wr1 = 1'b1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    wq1.delete();
    md = get1(3 * 64 + 5);
    for (int r = 0; r < 8; r++) md[r] = nd[r];
    model1[3 * 64 + 5] = md;
    #1;
    chk("mid_rst_busy", 32'(busy1), 0);
    chk("mid_rst_wd", 32'(wd1), 0);
    chk_m1("mid_rst_omat", omat1, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_t1(3, 5);

    // small build: latency 1, four rows, 70 tiles
    rd_t2(0, 0);
    wr_t2(3, 5, pat2(32'h88776655));
    rd_t2(3, 5);
    wr_t2(3, 69, pat2(32'h0badcafe));
    rd_t2(3, 69);
    sel2 = 9'(70);
    rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0;
    chk("tile70_err", 32'(err2), 1);
    chk("tile70_busy", 32'(busy2), 0);
    @(posedge clk); #1;
    chk("tile70_err_drop", 32'(err2), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rq1_drained", 32'(rq1.size()), 0);
    chk("wq1_drained", 32'(wq1.size()), 0);
    chk("rq2_drained", 32'(rq2.size()), 0);
    chk("wq2_drained", 32'(wq2.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
